// File: rtl/br_update_tracker.sv
// br_update_tracker: in-order tracker of gshare prediction metadata that emits predictor updates and mispredict pulses on resolve
//   clk, rst (sync, active-low)
//   enq_valid/enq_ready/enq_idx/enq_sc/enq_taken : prediction records from fetch
//   res_valid/res_is_branch/res_taken            : resolve of the oldest in-flight instruction
//   flush                                        : external pipeline flush
//   update_br_inst/update_br_taken/update_idx/update_sc : registered predictor update
//   mispredict, err_underflow                    : registered one-cycle pulses
//   count                                        : occupied entries
module br_update_tracker #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4,
    localparam int IW = $clog2(SIZE),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_valid,
    output logic          enq_ready,
    input  logic [IW-1:0] enq_idx,
    input  logic [1:0]    enq_sc,
    input  logic          enq_taken,
    input  logic          res_valid,
    input  logic          res_is_branch,
    input  logic          res_taken,
    input  logic          flush,
    output logic          update_br_inst,
    output logic          update_br_taken,
    output logic [IW-1:0] update_idx,
    output logic [1:0]    update_sc,
    output logic          mispredict,
    output logic [CW-1:0] count,
    output logic          err_underflow
);
    logic [IW-1:0] idx_q [DEPTH];
    logic [1:0]    sc_q  [DEPTH];
    logic          tk_q  [DEPTH];
    logic [PW-1:0] head, tail;
    logic          enq_fire, res_fire, mp, clear;

    assign enq_ready = count < CW'(DEPTH);
    assign enq_fire  = enq_valid && enq_ready;
    assign res_fire  = res_valid && count != '0;
    // a predicted-taken non-branch redirected fetch wrongly, so it counts as a mispredict
    assign mp        = res_fire && (res_is_branch ? (tk_q[head] != res_taken) : tk_q[head]);
    // flush or mispredict discards everything younger, including a same-cycle enqueue
    assign clear     = flush || mp;

    always_ff @(posedge clk) begin
        if (rst && enq_fire) begin
            idx_q[tail] <= enq_idx;
            sc_q[tail]  <= enq_sc;
            tk_q[tail]  <= enq_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            update_br_inst  <= 1'b0;
            update_br_taken <= 1'b0;
            update_idx      <= '0;
            update_sc       <= 2'b01;
            mispredict      <= 1'b0;
            err_underflow   <= 1'b0;
        end else begin
            head           <= clear ? '0 : head + PW'(res_fire);
            tail           <= clear ? '0 : tail + PW'(enq_fire);
            count          <= clear ? '0 : count + CW'(enq_fire) - CW'(res_fire);
            update_br_inst <= res_fire && res_is_branch;
            mispredict     <= mp;
            err_underflow  <= res_valid && count == '0;
            if (res_fire) begin
                update_br_taken <= res_taken;
                update_idx      <= idx_q[head];
                update_sc       <= sc_q[head];
            end
        end
    end
endmodule
